reg_bank_be: RTL and testbench
==============================

// Module: reg_bank_be
// PURPOSE
//  Parametrised bank of DEPTH byte-enabled registers, DATA_W bits each. Serves a
//  bus-side slave port with 1-cycle registered read latency and a core-side full-word
//  write port (e.g. AES result). Per-word dirty flags tell the core which words the
//  bus updated. Replaces banks of discrete 32-bit byte-enable registers in AES datapaths.
// PARAMETERS
//  DATA_W  32  word width in bits; must be a multiple of 8 (NB = DATA_W/8 byte lanes)
//  DEPTH   16  number of words; any value >= 2, need not be a power of two
//  ADDR_W  4   address width; 2**ADDR_W >= DEPTH
// PORTS
//  Clk        in   1             clock, all state on rising edge
//  Reset      in   1             asynchronous, active-high reset
//  wr         in   1             bus write strobe
//  rd         in   1             bus read strobe
//  addr       in   ADDR_W        bus word address
//  byte_en    in   NB            bus byte lane enables; any mask is legal
//  wdata      in   DATA_W        bus write data
//  rdata      out  DATA_W        bus read data, valid when rvalid=1
//  rvalid     out  1             read data valid, 1-cycle pulse per accepted read
//  hw_we      in   1             core write strobe, full word
//  hw_addr    in   ADDR_W        core write address
//  hw_din     in   DATA_W        core write data
//  dirty      out  DEPTH         bit i set when word i takes a bus write
//  dirty_clr  in   DEPTH         bit i clears dirty[i]
//  words_out  out  DEPTH*DATA_W  flat view of all words, word i at [i*DATA_W +: DATA_W]
//  par_inj    in   1             (REG_BANK_PARITY_EN only) corrupt parity on this write
//  par_err    out  1             (REG_BANK_PARITY_EN only) sticky parity error flag
// BEHAVIOUR
//  - Reset (async, any time): all words, rdata, rvalid, dirty, par_err -> 0. An
//    in-flight read is dropped: no rvalid after reset deasserts.
//  - Bus write: wr=1 at edge N -> byte lane b of word[addr] takes wdata lane b iff
//    byte_en[b]=1. Other lanes hold. byte_en=0 is a no-op and does not set dirty.
//  - Bus read: rd=1 at edge N -> rdata=word[addr], rvalid=1 after edge N. rvalid=0
//    after edge N+1 unless rd is still 1. rdata holds its last value while rvalid=0.
//    Back-to-back reads give one result per cycle.
//  - rd and wr in the same cycle to the same addr: read returns pre-write contents.
//    The write still commits.
//  - addr >= DEPTH: write ignored, no dirty change. Read returns 0 with rvalid=1.
//    Same rule applies to hw_addr >= DEPTH (write ignored).
//  - Core write: hw_we=1 -> word[hw_addr] <= hw_din, all lanes. dirty unaffected.
//  - Collision, wr & hw_we to same word: byte lanes with byte_en=1 take wdata; other
//    lanes take hw_din. Different words: both commit.
//  - dirty[i]: set on a bus write to word i with byte_en!=0. Cleared by dirty_clr[i].
//    Set and clear in the same cycle -> set wins.
//  - words_out reflects flop contents directly; updates the cycle after a write.
// CONFIGURATION
//  REG_BANK_PARITY_EN defined:
//   - One even-parity bit is stored per byte lane, written with each lane update.
//   - par_inj=1 during any write stores inverted parity for the lanes written.
//   - On each accepted read of an in-range word, parity is rechecked. Any lane
//     mismatch sets par_err (sticky until Reset). rdata is still returned unmodified.
//  REG_BANK_PARITY_EN undefined:
//   - par_inj and par_err ports are absent.
//   - No parity storage is built.
// TESTING
//  1 Reset, then read all DEPTH words -> each rdata=0, rvalid=1 one cycle after rd,
//    dirty=0.
//  2 Write addr 3, byte_en=4'b1111, 0xDEADBEEF. Then write addr 3, byte_en=4'b0101,
//    0x11223344 -> read 3 = 0xDE22BE44, dirty=16'h0008.
//  3 Same cycle: wr to addr 5 (byte_en=4'b1000, 0xAA000000) and hw_we to addr 5
//    (0x12345678) -> word 5 = 0xAA345678. Same cycle: rd and wr to addr 2 -> rdata
//    is the old value, then a following read returns the new value.
//  4 Set dirty[3] then pulse dirty_clr[3] with a new write to addr 3 in the same
//    cycle -> dirty[3] stays 1. Next cycle dirty_clr[3] alone -> dirty[3]=0.
//  5 DEPTH=12: write addr 13 -> no word changes. Read addr 13 -> rdata=0, rvalid=1.
//    rd asserted 4 cycles in a row -> 4 consecutive rvalid pulses. Reset asserted
//    mid-read -> rvalid=0, no late pulse.
//  6 (REG_BANK_PARITY_EN) Write addr 0 with par_inj=1, then read addr 0 -> par_err=1
//    and stays 1. Next Reset -> par_err=0.

Source files
------------

// File: rtl/reg_bank_be_if.sv
// Bus-side slave port of reg_bank_be: write/read strobes, byte enables and registered read return.
interface reg_bank_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  localparam int NB = DATA_W / 8;

  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [NB-1:0]     byte_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output wr, rd, addr, byte_en, wdata, input rdata, rvalid);
  modport slave  (input wr, rd, addr, byte_en, wdata, output rdata, rvalid);
endinterface

// File: rtl/reg_bank_be.sv
// Byte-enabled register bank with a bus port, a core full-word write port and per-word dirty flags.
// Optional per-lane even parity with a sticky error flag when REG_BANK_PARITY_EN is defined.
module reg_bank_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  reg_bank_be_if.slave             bus,
  input  logic                     hw_we_i,
  input  logic [ADDR_W-1:0]        hw_addr_i,
  input  logic [DATA_W-1:0]        hw_din_i,
  input  logic [DEPTH-1:0]         dirty_clr_i,
  output logic [DEPTH-1:0]         dirty_o,
`ifdef REG_BANK_PARITY_EN
  input  logic                     par_inj_i,
  output logic                     par_err_o,
`endif
  output logic [DEPTH*DATA_W-1:0]  words_out_o
);
  localparam int NB = DATA_W / 8;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             dirty_q, dirty_d;
  logic [DATA_W-1:0]            rdata_q, rdata_d;
  logic                         rvalid_q, rvalid_d;
  logic [DATA_W-1:0]            rd_word;

`ifdef REG_BANK_PARITY_EN
  logic [DEPTH-1:0][NB-1:0]     par_q, par_d;
  logic                         par_err_q, par_err_d;
  logic                         rd_perr;
`endif

  // Core write lands first, bus lanes overlay it: this yields the collision merge.
  always_comb begin
    mem_d   = mem_q;
    dirty_d = dirty_q & ~dirty_clr_i;
`ifdef REG_BANK_PARITY_EN
    par_d   = par_q;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (hw_we_i && hw_addr_i == ADDR_W'(i)) begin
        mem_d[i] = hw_din_i;
`ifdef REG_BANK_PARITY_EN
        for (int b = 0; b < NB; b++)
          par_d[i][b] = (^hw_din_i[b*8 +: 8]) ^ par_inj_i;
`endif
      end
      if (bus.wr && bus.addr == ADDR_W'(i)) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.byte_en[b]) begin
            mem_d[i][b*8 +: 8] = bus.wdata[b*8 +: 8];
`ifdef REG_BANK_PARITY_EN
            par_d[i][b] = (^bus.wdata[b*8 +: 8]) ^ par_inj_i;
`endif
          end
        end
        if (|bus.byte_en) dirty_d[i] = 1'b1;
      end
    end
  end

  // Out-of-range addresses match no word, so they read as zero.
  always_comb begin
    rd_word = '0;
`ifdef REG_BANK_PARITY_EN
    rd_perr = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.addr == ADDR_W'(i)) begin
        rd_word = mem_q[i];
`ifdef REG_BANK_PARITY_EN
        for (int b = 0; b < NB; b++)
          if ((^mem_q[i][b*8 +: 8]) != par_q[i][b]) rd_perr = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    rvalid_d = bus.rd;
    rdata_d  = bus.rd ? rd_word : rdata_q;
`ifdef REG_BANK_PARITY_EN
    par_err_d = par_err_q | (bus.rd & rd_perr);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      dirty_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef REG_BANK_PARITY_EN
      par_q     <= '0;
      par_err_q <= 1'b0;
`endif
    end else begin
      mem_q    <= mem_d;
      dirty_q  <= dirty_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
`ifdef REG_BANK_PARITY_EN
      par_q     <= par_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;
  assign dirty_o     = dirty_q;
  assign words_out_o = mem_q;
`ifdef REG_BANK_PARITY_EN
  assign par_err_o   = par_err_q;
`endif
endmodule

// File: tb/tb_reg_bank_be.sv
// Scoreboard bench for reg_bank_be (DEPTH=12 so addresses 12..15 are out of range).
module tb_reg_bank_be;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 12;
  localparam int ADDR_W = 4;

  logic                    clk, rst;
  logic                    hw_we;
  logic [ADDR_W-1:0]       hw_addr;
  logic [DATA_W-1:0]       hw_din;
  logic [DEPTH-1:0]        dirty_clr, dirty;
  logic [DEPTH*DATA_W-1:0] words_out;
`ifdef REG_BANK_PARITY_EN
  logic                    par_inj, par_err;
`endif

  reg_bank_be_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_bank_be #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .hw_we_i(hw_we), .hw_addr_i(hw_addr), .hw_din_i(hw_din),
    .dirty_clr_i(dirty_clr), .dirty_o(dirty),
`ifdef REG_BANK_PARITY_EN
    .par_inj_i(par_inj), .par_err_o(par_err),
`endif
    .words_out_o(words_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0, rv_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_w [DEPTH];

  function automatic void chk(string name, logic [DEPTH*DATA_W-1:0] act, logic [DEPTH*DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic chk_words(string name);
    logic [DEPTH*DATA_W-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i*DATA_W +: DATA_W] = exp_w[i];
    chk(name, words_out, v);
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding read.
  initial forever begin
    @(negedge clk);
    if (bus.rvalid === 1'b1) begin
      rv_cnt++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rvalid_unexpected: got rdata %0h with no read outstanding", bus.rdata);
      end else begin
        chk("rdata", DEPTH*DATA_W'(bus.rdata), DEPTH*DATA_W'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [DATA_W-1:0] d);
    bus.wr = 1'b1; bus.addr = a; bus.byte_en = be; bus.wdata = d;
    step();
    bus.wr = 1'b0; bus.byte_en = '0;
  endtask

  task automatic bus_rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    bus.rd = 1'b1; bus.addr = a; exp_q.push_back(e);
    step();
    bus.rd = 1'b0;
  endtask

  task automatic drain();
    step(); step();
    chk("queue_drained", DEPTH*DATA_W'(exp_q.size()), '0);
  endtask

  initial begin
    int rv0;
    rst = 1'b1; bus.wr = 0; bus.rd = 0; bus.addr = '0; bus.byte_en = '0; bus.wdata = '0;
    hw_we = 0; hw_addr = '0; hw_din = '0; dirty_clr = '0;
`ifdef REG_BANK_PARITY_EN
    par_inj = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) exp_w[i] = '0;
    #12;
    chk("reset_rvalid", DEPTH*DATA_W'(bus.rvalid), '0);
    chk("reset_dirty", DEPTH*DATA_W'(dirty), '0);
    chk("reset_rdata", DEPTH*DATA_W'(bus.rdata), '0);
    chk_words("reset_words");
    step(); rst = 1'b0; step();

    // 1: all words read zero
    for (int i = 0; i < DEPTH; i++) bus_rd(ADDR_W'(i), 32'h0);
    drain();
    chk("t1_rvalid_count", DEPTH*DATA_W'(rv_cnt), DEPTH*DATA_W'(DEPTH));
    chk("t1_dirty", DEPTH*DATA_W'(dirty), '0);

    // 2: byte-enable merge
    bus_wr(3, 4'b1111, 32'hDEADBEEF);
    bus_wr(3, 4'b0101, 32'h11223344);
    exp_w[3] = 32'hDE22BE44;
    chk("t2_dirty", DEPTH*DATA_W'(dirty), DEPTH*DATA_W'(12'h008));
    chk_words("t2_words");
    bus_rd(3, 32'hDE22BE44);
    drain();

    // 3: same-word collision, read-before-write, different-word dual write, empty mask
    hw_we = 1; hw_addr = 5; hw_din = 32'h12345678;
    bus_wr(5, 4'b1000, 32'hAA000000);
    hw_we = 0;
    exp_w[5] = 32'hAA345678;
    chk_words("t3_collision_words");
    bus.rd = 1; exp_q.push_back(32'h0);
    bus_wr(2, 4'b1111, 32'hCAFEF00D);
    bus.rd = 0;
    exp_w[2] = 32'hCAFEF00D;
    bus_rd(5, 32'hAA345678);
    bus_rd(2, 32'hCAFEF00D);
    drain();
    hw_we = 1; hw_addr = 8; hw_din = 32'h01020304;
    bus_wr(7, 4'b0011, 32'h1111BEEF);
    hw_we = 0;
    exp_w[7] = 32'h0000BEEF; exp_w[8] = 32'h01020304;
    bus_wr(9, 4'b0000, 32'hFFFFFFFF);
    chk_words("t3_dual_words");
    chk("t3_dirty", DEPTH*DATA_W'(dirty), DEPTH*DATA_W'(12'h0AC));

    // 4: set beats clear
    dirty_clr = 12'h008;
    bus_wr(3, 4'b0001, 32'h000000AA);
    exp_w[3] = 32'hDE22BEAA;
    chk("t4_set_wins", DEPTH*DATA_W'(dirty), DEPTH*DATA_W'(12'h0AC));
    step();
    dirty_clr = '0;
    chk("t4_clear", DEPTH*DATA_W'(dirty), DEPTH*DATA_W'(12'h0A4));

    // 5: out-of-range, burst, reset mid-read
    bus_wr(13, 4'b1111, 32'hFFFFFFFF);
    hw_we = 1; hw_addr = 14; hw_din = 32'h55555555;
    step();
    hw_we = 0;
    chk_words("t5_oor_words");
    chk("t5_oor_dirty", DEPTH*DATA_W'(dirty), DEPTH*DATA_W'(12'h0A4));
    bus_rd(13, 32'h0);
    drain();
    rv0 = rv_cnt;
    bus_rd(2, 32'hCAFEF00D);
    bus_rd(3, 32'hDE22BEAA);
    bus_rd(5, 32'hAA345678);
    bus_rd(7, 32'h0000BEEF);
    drain();
    chk("t5_burst_count", DEPTH*DATA_W'(rv_cnt - rv0), DEPTH*DATA_W'(4));
    rv0 = rv_cnt;
    bus.rd = 1; bus.addr = 3;
    @(posedge clk); #1;
    bus.rd = 0; rst = 1;
    #1;
    chk("t5_reset_rvalid", DEPTH*DATA_W'(bus.rvalid), '0);
    step(); step();
    rst = 0;
    step(); step(); step();
    chk("t5_no_late_pulse", DEPTH*DATA_W'(rv_cnt - rv0), '0);
    for (int i = 0; i < DEPTH; i++) exp_w[i] = '0;
    chk_words("t5_reset_words");
    chk("t5_reset_dirty", DEPTH*DATA_W'(dirty), '0);

`ifdef REG_BANK_PARITY_EN
    // 6: parity injection and sticky error
    bus_wr(1, 4'b1111, 32'h0F0F0F01);
    bus_rd(1, 32'h0F0F0F01);
    drain();
    chk("t6_clean_read", DEPTH*DATA_W'(par_err), '0);
    par_inj = 1;
    bus_wr(0, 4'b1111, 32'h12345678);
    par_inj = 0;
    chk("t6_no_err_before_read", DEPTH*DATA_W'(par_err), '0);
    bus_rd(0, 32'h12345678);
    drain();
    chk("t6_par_err", DEPTH*DATA_W'(par_err), DEPTH*DATA_W'(1));
    step(); step();
    chk("t6_sticky", DEPTH*DATA_W'(par_err), DEPTH*DATA_W'(1));
    rst = 1; step(); rst = 0; step();
    chk("t6_reset_clears", DEPTH*DATA_W'(par_err), '0);
`endif

    chk("final_queue_empty", DEPTH*DATA_W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
